module_sp: RTL and testbench

- Serial-to-parallel stage directly downstream of the parallel-to-serial transmitter.
- Consumes the 1-bit MSB-first stream on clk_32f, finds byte alignment on the 0xBC comma/idle symbol and declares link active after COMMA_COUNT consecutive aligned commas.
- Then delivers recovered bytes with a valid flag, where idle (0xBC) maps to valid low.
- Output bytes are held for 8 clk_32f cycles so a slower byte-rate consumer can sample them.

---
 rtl/module_sp_pkg.sv | 11 +
 rtl/module_sp_if.sv | 12 +
 rtl/module_sp_comma_det.sv | 24 ++
 rtl/module_sp.sv | 113 +++++++++++
 tb/tb_module_sp.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/module_sp_pkg.sv
// module_sp_pkg: shared constants and state encoding for the serial-to-parallel receiver
// Contents: COMMA idle/alignment symbol (also used by the transmitter), FSM state type, bit-counter width.
package sp_pkg;
    localparam logic [7:0] COMMA = 8'hBC;
    localparam int CNT_W = 3;
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCK   = 2'd1,
        ACTIVE = 2'd2
    } state_e;
endpackage

// File: rtl/module_sp_if.sv
// module_sp_if: serial-in / byte-out bundle of the receiver
// Signals: data_in_SP (serial bit, MSB first), data_out_SP[7:0], valid_out_SP, byte_strobe_SP, active_SP.
// Modports: master = stream source / byte consumer, slave = the receiver.
interface module_sp_if;
    logic       data_in_SP;
    logic [7:0] data_out_SP;
    logic       valid_out_SP;
    logic       byte_strobe_SP;
    logic       active_SP;
    modport master (output data_in_SP, input data_out_SP, valid_out_SP, byte_strobe_SP, active_SP);
    modport slave  (input data_in_SP, output data_out_SP, valid_out_SP, byte_strobe_SP, active_SP);
endinterface

// File: rtl/module_sp_comma_det.sv
// sp_comma_det: comma compare on the candidate byte plus the byte-phase counter
// Ports: clk_32f, reset_L (async, active-low), w_i candidate byte, locked_i (FSM out of SEARCH),
//        is_comma_o (w_i == COMMA), boundary_o (last bit of an aligned byte is being sampled).
module sp_comma_det
    import sp_pkg::*;
(
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic [7:0] w_i,
    input  logic       locked_i,
    output logic       is_comma_o,
    output logic       boundary_o
);
    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] bit_cnt_d;
    assign is_comma_o = w_i == COMMA;
    assign boundary_o = locked_i && bit_cnt_q == '1;
    // Held at 0 while hunting so the first locked cycle starts phase 0 right after detection.
    assign bit_cnt_d  = locked_i ? bit_cnt_q + CNT_W'(1) : '0;
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) bit_cnt_q <= '0;
        else          bit_cnt_q <= bit_cnt_d;
    end
endmodule

// File: rtl/module_sp.sv
// module_sp: serial-to-parallel receiver with comma alignment and link-active detection
// Ports: clk_32f (bit clock), reset_L (async, active-low), sp (module_sp_if.slave):
//        data_in_SP serial in; data_out_SP/valid_out_SP held byte + valid; byte_strobe_SP
//        boundary pulse; active_SP link synchronized.
// Optional: define SP_RESYNC_EN to drop back to SEARCH after RUN_LIMIT consecutive non-comma bytes.
module module_sp
    import sp_pkg::*;
#(
    parameter int unsigned COMMA_COUNT = 4,
    parameter int unsigned RUN_LIMIT   = 16
) (
    input logic        clk_32f,
    input logic        reset_L,
    module_sp_if.slave sp
);
    localparam logic [4:0] CC = 5'(COMMA_COUNT);
    if (COMMA_COUNT < 1 || COMMA_COUNT > 15 || RUN_LIMIT < 1 || RUN_LIMIT > 31) begin : g_bad_param
        $error("module_sp: COMMA_COUNT must be 1..15 and RUN_LIMIT 1..31");
    end
    state_e     state_q;
    logic [6:0] sh_q;
    logic [3:0] bc_cnt_q;
    logic [7:0] data_q;
    logic       valid_q;
    logic       strobe_q;
    logic       active_q;
    logic [7:0] w;
    logic [4:0] bc_inc;
    logic [3:0] bc_sat;
    logic       is_comma;
    logic       boundary;
`ifdef SP_RESYNC_EN
    localparam logic [4:0] RL = 5'(RUN_LIMIT);
    logic [4:0] run_q;
    logic [4:0] run_inc;
    assign run_inc = run_q + 5'd1;
`endif
    // Candidate byte includes the bit arriving this edge, so bytes appear with no extra latency.
    assign w      = {sh_q, sp.data_in_SP};
    assign bc_inc = {1'b0, bc_cnt_q} + 5'd1;
    assign bc_sat = &bc_cnt_q ? bc_cnt_q : bc_inc[3:0];
    sp_comma_det u_det (
        .clk_32f    (clk_32f),
        .reset_L    (reset_L),
        .w_i        (w),
        .locked_i   (state_q != SEARCH),
        .is_comma_o (is_comma),
        .boundary_o (boundary)
    );
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state_q  <= SEARCH;
            sh_q     <= '0;
            bc_cnt_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            active_q <= 1'b0;
`ifdef SP_RESYNC_EN
            run_q    <= '0;
`endif
        end else begin
            sh_q     <= w[6:0];
            strobe_q <= 1'b0;
            case (state_q)
                SEARCH: if (is_comma) begin
                    strobe_q <= 1'b1;
                    bc_cnt_q <= 4'd1;
                    state_q  <= COMMA_COUNT == 1 ? ACTIVE : LOCK;
                    active_q <= COMMA_COUNT == 1;
                end
                LOCK: if (boundary) begin
                    strobe_q <= 1'b1;
                    if (!is_comma) begin
                        state_q  <= SEARCH;
                        bc_cnt_q <= '0;
                    end else begin
                        bc_cnt_q <= bc_sat;
                        if (bc_inc == CC) begin
                            state_q  <= ACTIVE;
                            active_q <= 1'b1;
                        end
                    end
                end
                ACTIVE: if (boundary) begin
                    strobe_q <= 1'b1;
`ifdef SP_RESYNC_EN
                    // Too long without an aligned comma: drop sync but keep the last byte on the bus.
                    if (!is_comma && run_inc == RL) begin
                        state_q  <= SEARCH;
                        active_q <= 1'b0;
                        valid_q  <= 1'b0;
                        bc_cnt_q <= '0;
                        run_q    <= '0;
                    end else begin
                        data_q  <= w;
                        valid_q <= !is_comma;
                        run_q   <= is_comma ? 5'd0 : run_inc;
                    end
`else
                    data_q  <= w;
                    valid_q <= !is_comma;
`endif
                end
                default: state_q <= SEARCH;
            endcase
        end
    end
    assign sp.data_out_SP    = data_q;
    assign sp.valid_out_SP   = valid_q;
    assign sp.byte_strobe_SP = strobe_q;
    assign sp.active_SP      = active_q;
endmodule

// File: tb/tb_module_sp.sv
// tb_module_sp: self-checking bench for module_sp against a byte-level reference model
module tb_module_sp;
    import sp_pkg::*;
    localparam int CC   = 4;
    localparam int RL   = 16;
    localparam int MAXN = 1024;
    logic clk_32f = 1'b0;
    logic reset_L = 1'b0;
    int checks = 0;
    int failures = 0;
    bit bits[$];
    logic [7:0] exp_d[MAXN];
    logic       exp_v[MAXN];
    logic       exp_s[MAXN];
    logic       exp_a[MAXN];
    logic [7:0] obs_d[MAXN];
    logic       obs_v[MAXN];
    logic       obs_s[MAXN];
    logic       obs_a[MAXN];
    module_sp_if sp_if ();
    module_sp #(.COMMA_COUNT(CC), .RUN_LIMIT(RL)) dut (
        .clk_32f (clk_32f),
        .reset_L (reset_L),
        .sp      (sp_if.slave)
    );
    initial forever #5 clk_32f = ~clk_32f;
    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s edge=%0d got=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask
    function automatic logic [7:0] win(input int k);
        logic [7:0] w = '0;
        for (int j = 0; j < 8; j++) w = {w[6:0], logic'(bits[k-7+j])};
        return w;
    endfunction
    task automatic push_byte(input logic [7:0] b);
        for (int j = 7; j >= 0; j--) bits.push_back(b[j]);
    endtask
    // Walks the bit stream byte by byte: hunt for a comma at any offset, demand COMMA_COUNT
    // aligned commas, then emit every aligned byte; results become per-edge expected outputs.
    task automatic build_model();
        int n = bits.size();
        int k = 7;
        int cnt;
        int run;
        bit ok;
        bit done = 0;
        bit ev_str[MAXN], ev_load[MAXN], ev_act[MAXN], ev_drop[MAXN];
        logic [7:0] d = '0;
        logic v = 0, a = 0;
        for (int i = 0; i < n; i++) begin
            ev_str[i] = 0; ev_load[i] = 0; ev_act[i] = 0; ev_drop[i] = 0;
        end
        while (k < n && !done) begin
            if (win(k) != COMMA) begin
                k++;
                continue;
            end
            ev_str[k] = 1;
            cnt = 1;
            ok = (CC == 1);
            while (!ok && !done) begin
                k += 8;
                if (k >= n) done = 1;
                else begin
                    ev_str[k] = 1;
                    if (win(k) != COMMA) break;
                    cnt++;
                    ok = (cnt == CC);
                end
            end
            if (done) break;
            if (!ok) begin
                k++;
                continue;
            end
            ev_act[k] = 1;
            run = 0;
            while (!done) begin
                k += 8;
                if (k >= n) done = 1;
                else begin
                    ev_str[k] = 1;
`ifdef SP_RESYNC_EN
                    run = (win(k) == COMMA) ? 0 : run + 1;
                    if (run == RL) begin
                        ev_drop[k] = 1;
                        break;
                    end
`endif
                    ev_load[k] = 1;
                end
            end
            k++;
        end
        for (int i = 0; i < n; i++) begin
            if (ev_act[i]) a = 1;
            if (ev_drop[i]) begin a = 0; v = 0; end
            if (ev_load[i]) begin d = win(i); v = (win(i) != COMMA); end
            exp_d[i] = d; exp_v[i] = v; exp_s[i] = ev_str[i]; exp_a[i] = a;
        end
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_data"},   -1, sp_if.data_out_SP, 8'h00);
        chk({tag, "_valid"},  -1, {7'd0, sp_if.valid_out_SP}, 8'h00);
        chk({tag, "_strobe"}, -1, {7'd0, sp_if.byte_strobe_SP}, 8'h00);
        chk({tag, "_active"}, -1, {7'd0, sp_if.active_SP}, 8'h00);
    endtask
    // Resets, then plays the stream and compares every edge; stop_at >= 0 aborts with an async reset.
    task automatic run_seg(input int stop_at);
        int n = bits.size();
        build_model();
        reset_L = 1'b0;
        sp_if.data_in_SP = 1'b0;
        @(negedge clk_32f);
        #1 chk_zero("reset");
        reset_L = 1'b1;
        @(negedge clk_32f);
        for (int k = 0; k < n; k++) begin
            sp_if.data_in_SP = bits[k];
            @(posedge clk_32f);
            #1;
            obs_d[k] = sp_if.data_out_SP;
            obs_v[k] = sp_if.valid_out_SP;
            obs_s[k] = sp_if.byte_strobe_SP;
            obs_a[k] = sp_if.active_SP;
            chk("data",   k, obs_d[k], exp_d[k]);
            chk("valid",  k, {7'd0, obs_v[k]}, {7'd0, exp_v[k]});
            chk("strobe", k, {7'd0, obs_s[k]}, {7'd0, exp_s[k]});
            chk("active", k, {7'd0, obs_a[k]}, {7'd0, exp_a[k]});
            if (k == stop_at) begin
                #2 reset_L = 1'b0;
                #1 chk_zero("async_reset");
                break;
            end
            @(negedge clk_32f);
        end
    endtask
    task automatic commas(input int c);
        repeat (c) push_byte(COMMA);
    endtask
    task automatic gen_rand(input int nbytes);
        bits.delete();
        repeat ($urandom_range(12)) bits.push_back($urandom_range(1) != 0);
        if ($urandom_range(3) != 0) commas(CC);
        repeat (nbytes) push_byte(($urandom_range(99) < 35) ? COMMA : 8'($urandom));
    endtask
    initial begin
        // alignment after a 3-bit misaligned prefix
        bits.delete();
        bits.push_back(1); bits.push_back(0); bits.push_back(1);
        commas(4); push_byte(8'hA5); push_byte(COMMA);
        run_seg(-1);
        chk("align_not_yet", 33, {7'd0, obs_a[33]}, 8'h00);
        chk("align_active", 34, {7'd0, obs_a[34]}, 8'h01);
        chk("align_data", 42, obs_d[42], 8'hA5);
        for (int k = 42; k < 50; k++) chk("align_hold_valid", k, {7'd0, obs_v[k]}, 8'h01);
        // broken sync restarts the hunt
        bits.delete();
        commas(2); push_byte(8'h00); commas(4); push_byte(8'h3C);
        run_seg(-1);
        chk("broken_not_yet", 54, {7'd0, obs_a[54]}, 8'h00);
        chk("broken_active", 55, {7'd0, obs_a[55]}, 8'h01);
        chk("broken_data", 63, obs_d[63], 8'h3C);
        chk("broken_valid", 63, {7'd0, obs_v[63]}, 8'h01);
        // idle symbol inside ACTIVE
        bits.delete();
        commas(4); push_byte(8'h7E); push_byte(COMMA); push_byte(8'h81);
        run_seg(-1);
        chk("idle_v0", 39, {7'd0, obs_v[39]}, 8'h01);
        chk("idle_v1", 47, {7'd0, obs_v[47]}, 8'h00);
        chk("idle_v2", 55, {7'd0, obs_v[55]}, 8'h01);
        chk("idle_strobe", 47, {7'd0, obs_s[47]}, 8'h01);
        chk("idle_no_strobe", 48, {7'd0, obs_s[48]}, 8'h00);
        // comma pattern straddling a boundary must not realign
        bits.delete();
        commas(4); push_byte(8'h5E); push_byte(8'h00); push_byte(COMMA);
        run_seg(-1);
        chk("immune_d0", 39, obs_d[39], 8'h5E);
        chk("immune_d1", 47, obs_d[47], 8'h00);
        chk("immune_v1", 47, {7'd0, obs_v[47]}, 8'h01);
        // long non-comma runs
        bits.delete();
        commas(4); repeat (15) push_byte(8'h55); push_byte(COMMA); repeat (16) push_byte(8'h55);
        run_seg(-1);
        chk("run15_active", 159, {7'd0, obs_a[159]}, 8'h01);
        chk("run16_before", 286, {7'd0, obs_a[286]}, 8'h01);
`ifdef SP_RESYNC_EN
        chk("run16_active", 287, {7'd0, obs_a[287]}, 8'h00);
        chk("run16_data_kept", 287, obs_d[287], 8'h55);
`else
        chk("run16_active", 287, {7'd0, obs_a[287]}, 8'h01);
`endif
        // random streams, some cut short by an asynchronous reset
        for (int s = 0; s < 8; s++) begin
            gen_rand(30);
            run_seg((s % 3 == 2) ? int'($urandom_range(bits.size() - 1)) : -1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
